// File: rtl/v_div.sv
// SEW-packed restoring divider: 4x8 / 2x16 / 1x32 lanes, quotient or remainder, signed or unsigned.
// Latency W+2 cycles from the accepting edge to done (2 for reserved SEW); start is ignored while busy.
module v_div (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [1:0]  sew_i,
    input  logic        is_signed_i,
    input  logic        is_rem_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);
    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] a_q, b_q, r_q, orig_q, result_q;
    logic [1:0]  sew_q;
    logic        sgn_q, rem_q, busy_q, done_q;
    logic [3:0]  sa_q, sb_q, dz_q, ov_q;

    // Lane split: signs, magnitudes and special-case flags from the raw captured operands.
    logic [31:0] mag_a, mag_b;
    logic [3:0]  sa_d, sb_d, dz_d, ov_d;
    logic [4:0]  wm1;

    always_comb begin
        mag_a = a_q;
        mag_b = b_q;
        sa_d  = '0;
        sb_d  = '0;
        dz_d  = '0;
        ov_d  = '0;
        wm1   = 5'd31;
        case (sew_q)
            2'b00: begin
                wm1 = 5'd7;
                for (int l = 0; l < 4; l++) begin
                    sa_d[l] = sgn_q & a_q[8*l+7];
                    sb_d[l] = sgn_q & b_q[8*l+7];
                    if (sa_d[l]) mag_a[8*l+:8] = -a_q[8*l+:8];
                    if (sb_d[l]) mag_b[8*l+:8] = -b_q[8*l+:8];
                    dz_d[l] = (b_q[8*l+:8] == 8'h00);
                    ov_d[l] = sgn_q && (a_q[8*l+:8] == 8'h80) && (b_q[8*l+:8] == 8'hFF);
                end
            end
            2'b01: begin
                wm1 = 5'd15;
                for (int l = 0; l < 2; l++) begin
                    sa_d[l] = sgn_q & a_q[16*l+15];
                    sb_d[l] = sgn_q & b_q[16*l+15];
                    if (sa_d[l]) mag_a[16*l+:16] = -a_q[16*l+:16];
                    if (sb_d[l]) mag_b[16*l+:16] = -b_q[16*l+:16];
                    dz_d[l] = (b_q[16*l+:16] == 16'h0000);
                    ov_d[l] = sgn_q && (a_q[16*l+:16] == 16'h8000) && (b_q[16*l+:16] == 16'hFFFF);
                end
            end
            2'b10: begin
                sa_d[0] = sgn_q & a_q[31];
                sb_d[0] = sgn_q & b_q[31];
                if (sa_d[0]) mag_a = -a_q;
                if (sb_d[0]) mag_b = -b_q;
                dz_d[0] = (b_q == 32'h0);
                ov_d[0] = sgn_q && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
            end
            default: ;
        endcase
    end

    // One restoring step per lane; the quotient bit shifts into the vacated dividend LSB.
    logic [31:0] a_n, r_n;
    logic [8:0]  sh9, d9;
    logic [16:0] sh17, d17;
    logic [32:0] sh33, d33;

    always_comb begin
        a_n  = a_q;
        r_n  = r_q;
        sh9  = '0;
        d9   = '0;
        sh17 = '0;
        d17  = '0;
        sh33 = '0;
        d33  = '0;
        case (sew_q)
            2'b00: begin
                for (int l = 0; l < 4; l++) begin
                    sh9 = {r_q[8*l+:8], a_q[8*l+7]};
                    d9  = sh9 - {1'b0, b_q[8*l+:8]};
                    r_n[8*l+:8] = d9[8] ? sh9[7:0] : d9[7:0];
                    a_n[8*l+:8] = {a_q[8*l+:7], ~d9[8]};
                end
            end
            2'b01: begin
                for (int l = 0; l < 2; l++) begin
                    sh17 = {r_q[16*l+:16], a_q[16*l+15]};
                    d17  = sh17 - {1'b0, b_q[16*l+:16]};
                    r_n[16*l+:16] = d17[16] ? sh17[15:0] : d17[15:0];
                    a_n[16*l+:16] = {a_q[16*l+:15], ~d17[16]};
                end
            end
            2'b10: begin
                sh33 = {r_q, a_q[31]};
                d33  = sh33 - {1'b0, b_q};
                r_n  = d33[32] ? sh33[31:0] : d33[31:0];
                a_n  = {a_q[30:0], ~d33[32]};
            end
            default: ;
        endcase
    end

    // Sign correction and special cases, applied to the outcome of the final step.
    logic [31:0] res_n;
    logic [7:0]  q8, r8;
    logic [15:0] q16, r16;
    logic [31:0] q32, r32;

    always_comb begin
        res_n = '0;
        q8    = '0;
        r8    = '0;
        q16   = '0;
        r16   = '0;
        q32   = '0;
        r32   = '0;
        case (sew_q)
            2'b00: begin
                for (int l = 0; l < 4; l++) begin
                    q8 = a_n[8*l+:8];
                    r8 = r_n[8*l+:8];
                    if (sa_q[l] ^ sb_q[l]) q8 = -q8;
                    if (sa_q[l]) r8 = -r8;
                    if (dz_q[l]) begin q8 = 8'hFF; r8 = orig_q[8*l+:8]; end
                    if (ov_q[l]) begin q8 = orig_q[8*l+:8]; r8 = 8'h00; end
                    res_n[8*l+:8] = rem_q ? r8 : q8;
                end
            end
            2'b01: begin
                for (int l = 0; l < 2; l++) begin
                    q16 = a_n[16*l+:16];
                    r16 = r_n[16*l+:16];
                    if (sa_q[l] ^ sb_q[l]) q16 = -q16;
                    if (sa_q[l]) r16 = -r16;
                    if (dz_q[l]) begin q16 = 16'hFFFF; r16 = orig_q[16*l+:16]; end
                    if (ov_q[l]) begin q16 = orig_q[16*l+:16]; r16 = 16'h0000; end
                    res_n[16*l+:16] = rem_q ? r16 : q16;
                end
            end
            2'b10: begin
                q32 = a_n;
                r32 = r_n;
                if (sa_q[0] ^ sb_q[0]) q32 = -q32;
                if (sa_q[0]) r32 = -r32;
                if (dz_q[0]) begin q32 = 32'hFFFF_FFFF; r32 = orig_q; end
                if (ov_q[0]) begin q32 = orig_q; r32 = 32'h0; end
                res_n = rem_q ? r32 : q32;
            end
            default: ;
        endcase
    end

    // The fix-up is folded into the last iteration edge so done lands W+2 cycles after accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            orig_q   <= '0;
            result_q <= '0;
            sew_q    <= '0;
            sgn_q    <= 1'b0;
            rem_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sa_q     <= '0;
            sb_q     <= '0;
            dz_q     <= '0;
            ov_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= start_i;
                    if (start_i) begin
                        a_q     <= op_a_i;
                        b_q     <= op_b_i;
                        orig_q  <= op_a_i;
                        sew_q   <= sew_i;
                        sgn_q   <= is_signed_i;
                        rem_q   <= is_rem_i;
                        state_q <= PREP;
                    end
                end
                PREP: begin
                    a_q   <= mag_a;
                    b_q   <= mag_b;
                    r_q   <= '0;
                    sa_q  <= sa_d;
                    sb_q  <= sb_d;
                    dz_q  <= dz_d;
                    ov_q  <= ov_d;
                    cnt_q <= wm1;
                    if (sew_q == 2'b11) begin
                        result_q <= '0;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    a_q <= a_n;
                    r_q <= r_n;
                    if (cnt_q == 5'd0) begin
                        result_q <= res_n;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
endmodule

// File: tb/tb_v_div.sv
// Bench for v_div: directed vector table, handshake/reset sequences and randomized ops against an arithmetic model.
module tb_v_div;
    logic        clk = 1'b0;
    logic        rst, start, sgn, rem;
    logic [31:0] op_a, op_b;
    logic [1:0]  sew;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fails  = 0;

    v_div dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_a_i(op_a), .op_b_i(op_b),
        .sew_i(sew), .is_signed_i(sgn), .is_rem_i(rem),
        .busy_o(busy), .done_o(done), .result_o(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-lane integer division straight from the arithmetic definition.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] s, input logic sg, input logic rm);
        int w, n;
        longint m, av, bv, q, r;
        logic [31:0] res;
        if (s == 2'b11) return 32'h0;
        w = 8 << s;
        n = 32 / w;
        m = (longint'(1) << w) - 1;
        res = 32'h0;
        for (int l = 0; l < n; l++) begin
            av = (longint'(a) >> (w*l)) & m;
            bv = (longint'(b) >> (w*l)) & m;
            if (sg) begin
                if (av >= (longint'(1) << (w-1))) av = av - (m + 1);
                if (bv >= (longint'(1) << (w-1))) bv = bv - (m + 1);
            end
            if (bv == 0) begin
                q = -1; r = av;
            end else if (sg && bv == -1 && av == -(longint'(1) << (w-1))) begin
                q = av; r = 0;
            end else begin
                q = av / bv; r = av % bv;
            end
            res = res | 32'(((rm ? r : q) & m) << (w*l));
        end
        return res;
    endfunction

    function automatic int lat_of(input logic [1:0] s);
        return (s == 2'b11) ? 2 : (8 << s) + 2;
    endfunction

    // Called one step after a rising edge; returns one step after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                         input logic sg, input logic rm);
        op_a = a; op_b = b; sew = s; sgn = sg; rem = rm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; sew = 2'($urandom); sgn = 1'($urandom); rem = 1'($urandom);
    endtask

    task automatic wait_done(output logic [31:0] res, output int lat, output bit busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat <= 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        if (!done) check("done_timeout", {31'h0, done}, 32'h1);
        res = result;
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic [1:0]  s;
        logic        sg, rm;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t        tbl[9];
        logic [31:0] res, a, b;
        logic [1:0]  s;
        logic        sg, rm;
        int          lat, ndone;
        bit          bok;

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; sew = '0; sgn = 1'b0; rem = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        tbl[0] = '{32'hF9640A07, 32'h02FF0302, 2'b00, 1'b1, 1'b0, 32'hFD9C0303, 10};
        tbl[1] = '{32'hF9640A07, 32'h02FF0302, 2'b00, 1'b1, 1'b1, 32'hFF000101, 10};
        tbl[2] = '{32'hFFFFFFFF, 32'h00000010, 2'b10, 1'b0, 1'b0, 32'h0FFFFFFF, 34};
        tbl[3] = '{32'hFFFFFFFF, 32'h00000010, 2'b10, 1'b0, 1'b1, 32'h0000000F, 34};
        tbl[4] = '{32'h00000064, 32'h00000000, 2'b10, 1'b0, 1'b0, 32'hFFFFFFFF, 34};
        tbl[5] = '{32'h00000064, 32'h00000000, 2'b10, 1'b0, 1'b1, 32'h00000064, 34};
        tbl[6] = '{32'h80008000, 32'hFFFF0001, 2'b01, 1'b1, 1'b0, 32'h80008000, 18};
        tbl[7] = '{32'h80008000, 32'hFFFF0001, 2'b01, 1'b1, 1'b1, 32'h00000000, 18};
        tbl[8] = '{32'h12345678, 32'h9ABCDEF0, 2'b11, 1'b1, 1'b0, 32'h00000000, 2};

        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].sg, tbl[i].rm);
            wait_done(res, lat, bok);
            check($sformatf("vec%0d_result", i), res, tbl[i].exp_res);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("vec%0d_busy", i), {31'h0, bok}, 32'h1);
        end

        // start pulsed mid-operation must be ignored
        issue(32'hF9640A07, 32'h02FF0302, 2'b00, 1'b1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        op_a = 32'h11111111; op_b = 32'h01010101; sew = 2'b11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(res, lat, bok);
        check("ignore_result", res, 32'hFD9C0303);
        check("ignore_latency", 32'(lat + 3), 32'd10);
        ndone = 0;
        repeat (15) begin @(posedge clk); #1; if (done) ndone++; end
        check("ignore_no_extra_done", 32'(ndone), 32'd0);

        // back-to-back: second start raised during the done cycle
        issue(32'h7F10C8FF, 32'h03F70505, 2'b00, 1'b1, 1'b1);
        wait_done(res, lat, bok);
        check("b2b_first_result", res, model(32'h7F10C8FF, 32'h03F70505, 2'b00, 1'b1, 1'b1));
        issue(32'hABCD1234, 32'h00070011, 2'b01, 1'b0, 1'b0);
        wait_done(res, lat, bok);
        check("b2b_second_result", res, model(32'hABCD1234, 32'h00070011, 2'b01, 1'b0, 1'b0));
        check("b2b_second_latency", 32'(lat), 32'd18);

        // reset five cycles into a 32-bit divide
        issue(32'hFFFFFFFF, 32'h00000010, 2'b10, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_result", result, 32'h0);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
        check("abort_no_done", 32'(ndone), 32'd0);
        issue(32'hFFFFFFF9, 32'h00000002, 2'b10, 1'b1, 1'b0);
        wait_done(res, lat, bok);
        check("after_abort_result", res, 32'hFFFFFFFD);
        check("after_abort_latency", 32'(lat), 32'd34);

        // randomized operations against the model
        for (int i = 0; i < 80; i++) begin
            a  = $urandom;
            b  = $urandom;
            s  = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            rm = 1'($urandom);
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: begin a = 32'h80808080; b = 32'hFFFFFFFF; end
                3: b = b & 32'h0F0F0F0F;
                default: ;
            endcase
            issue(a, b, s, sg, rm);
            wait_done(res, lat, bok);
            check($sformatf("rand%0d_result a=%h b=%h sew=%0d s=%0d r=%0d", i, a, b, s, sg, rm),
                  res, model(a, b, s, sg, rm));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(lat_of(s)));
            check($sformatf("rand%0d_busy", i), {31'h0, bok}, 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/v_div.md
# v_div

Iterative SEW-packed integer divider for the vector execution lane, sitting alongside the pipelined multiplier as its inverse arithmetic unit. It accepts one 32-bit operand pair per request and computes VDIV/VDIVU or VREM/VREMU on 4×8, 2×16 or 1×32-bit elements in parallel. It uses restoring shift-subtract, one quotient bit per lane per cycle, with a start/busy/done handshake. Lane packing and SEW encoding match the multiplier, so results merge into the same writeback path.

## Interface
- No parameters. Datapath fixed at 32 bits; lane widths are set by `sew`.
- `clk` in 1: rising-edge clock, the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request strobe; sampled only in IDLE.
- `op_A` in 32: dividend(s), packed lanes with lane 0 in the LSBs.
- `op_B` in 32: divisor(s), packed the same way.
- `sew` in 2: 00 = 8-bit ×4, 01 = 16-bit ×2, 10 = 32-bit ×1, 11 = reserved.
- `is_signed` in 1: 1 = two's-complement (VDIV/VREM), 0 = unsigned.
- `is_rem` in 1: 1 = return remainders, 0 = return quotients.
- `busy` out 1: high from the accepting edge until `done`, inclusive.
- `done` out 1: one-cycle pulse; `result` is valid from this cycle on.
- `result` out 32: packed per-lane results, held until the next accepted `start`.

## Operation
- **Input capture:** `op_A`, `op_B`, `sew`, `is_signed` and `is_rem` are captured on the accepting edge. Later input changes have no effect.
- **FSM states:** IDLE, PREP, ITER, FIX.
- **IDLE → PREP:** taken when `start` is high.
- **PREP:**
  - Splits operands into lanes of width W (8/16/32).
  - For signed lanes, records the sign of dividend and divisor and takes magnitudes.
  - Flags per lane: divide-by-zero (divisor == 0) and overflow (signed, dividend = most-negative, divisor = −1).
  - Goes to ITER with bit counter = W−1.
- **ITER:** each cycle, every lane does:
  - Shift {remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude.
  - Keep the difference if it is non-negative and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - The counter decrements. When it reaches 0, go to FIX.
  - ITER takes exactly W cycles.
- **FIX (per lane):**
  - Normal lane: negate the quotient if the operand signs differ (signed only). Negate the remainder if the dividend was negative (signed only). The quotient truncates toward zero.
  - Divide-by-zero: quotient = all ones; remainder = original dividend.
  - Overflow: quotient = original dividend; remainder = 0.
- **FIX output:** the selected quotient or remainder of each lane is packed into the `result` register, `done` is pulsed, and the FSM returns to IDLE.
- **Width rules:** lane remainders are W+1 bits wide internally. Lanes never exchange carries or borrows.
- **sew = 11:** accepted, but skips ITER (PREP → FIX). `result` = 0.
- **`start` while not IDLE:** ignored. No queueing and no restart.
- **`start` in the cycle `done` is high:** accepted, because the FSM is already in IDLE that cycle. Back-to-back operation has no bubble beyond the done cycle.
- **Reset (including mid-operation):** FSM → IDLE, `busy` = 0, `done` = 0, `result` = 0, counter = 0. An aborted operation never raises `done`.

## Timing
- **Edge numbering:** E0 is the edge that samples `start` in IDLE.
- **`busy`:** high in the cycles following E0 through the `done` cycle.
- **`done`:** high for exactly one cycle after edge E0+W+1.
- **Total latency:** W+2 cycles, counted from E0 to the cycle `done` is high.
  - sew 00: 10 cycles
  - sew 01: 18 cycles
  - sew 10: 34 cycles
  - sew 11: 2 cycles
- **Reset values:** `busy` = 0, `done` = 0, `result` = 0x00000000.
- **Sustained throughput:** one operation every W+2 cycles.

## Test plan
- **Signed quotient, sew 00:** `op_A` = 0xF9640A07, `op_B` = 0x02FF0302, `is_signed` = 1, `is_rem` = 0 → `result` = 0xFD9C0303, `done` 10 cycles after `start`. Same operands with `is_rem` = 1 → `result` = 0xFF000101.
- **Unsigned, sew 10:** `op_A` = 0xFFFFFFFF, `op_B` = 0x00000010 → quotient 0x0FFFFFFF, remainder 0x0000000F. `busy` stays high for 34 cycles.
- **Special cases:**
  - sew 10, `op_A` = 0x00000064, `op_B` = 0 → quotient 0xFFFFFFFF, remainder 0x00000064.
  - sew 01 signed, `op_A` = 0x80008000, `op_B` = 0xFFFF0001 → quotient 0x80008000, remainder 0x00000000.
- **Handshake:**
  - Pulse `start` again 3 cycles after acceptance with different operands → ignored; the original result is returned.
  - Assert `start` in the `done` cycle → the second operation completes W+2 cycles later.
- **Reset mid-operation:** assert `rst` 5 cycles into a sew 10 divide → the next cycle shows `busy` = 0, `result` = 0, and `done` never rises. A subsequent `start` completes normally.
- **Reserved SEW:** sew 11 with any operands → `done` after 2 cycles, `result` = 0.
